// File: rtl/led_trail_fader_if.sv
// Pattern/enable inputs and LED drive outputs of the trail fader.
// Master side is the pattern source; slave side is the fader itself.
// Pure wiring; no state.
interface led_trail_fader_if;
  logic [7:0] pattern_in;
  logic       enable;
  logic [7:0] leds_out;
  logic       active;

  modport master (output pattern_in, output enable, input leds_out, input active);
  modport slave  (input pattern_in, input enable, output leds_out, output active);
endinterface

// File: rtl/led_trail_fader.sv
// Per-LED PWM fader: lit bits jump to full brightness, dark bits decay linearly per tick.
// Latency: 3 clocks from pattern_in bit rising to the LED output lit (pattern_q, lvl, leds_out).
// No backpressure: free-running stage, samples pattern_in every cycle.
module led_trail_fader #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int FADE_HZ   = 1_000,
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 8
) (
  input logic               clk,
  input logic               rst_n,
  led_trail_fader_if.slave  bus
);

  localparam int TICK_DIV = CLK_FREQ / FADE_HZ;
  // Keep at least one bit so TICK_DIV == 1 still elaborates.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(FADE_STEP);
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);

  logic [7:0]          pattern_q;
  logic [PWM_BITS-1:0] lvl     [8];
  logic [PWM_BITS-1:0] lvl_nxt [8];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [TW-1:0]       tick_cnt;
  logic [7:0]          leds_q;
  logic [7:0]          leds_nxt;
  logic                active_q;
  logic                any_lit;
  logic                tick;

  assign tick         = (tick_cnt == TICK_LAST);
  assign bus.leds_out = leds_q;
  assign bus.active   = active_q;

  // Next brightness: disable clears, attack beats decay, decay saturates at zero.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl_nxt[i] = lvl[i];
      if (!bus.enable) begin
        lvl_nxt[i] = '0;
      end else if (pattern_q[i]) begin
        lvl_nxt[i] = MAX;
      end else if (tick) begin
        lvl_nxt[i] = (lvl[i] < STEP) ? '0 : lvl[i] - STEP;
      end
    end
  end

  // PWM compare and activity flag, both from the levels before this cycle's update.
  always_comb begin
    leds_nxt = '0;
    any_lit  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      leds_nxt[i] = bus.enable && (pwm_cnt < lvl[i]);
      if (lvl[i] != '0) begin
        any_lit = 1'b1;
      end
    end
  end

  // Pattern register keeps sampling even while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
    end else begin
      pattern_q <= bus.pattern_in;
    end
  end

  // Prescaler and PWM phase; both parked at zero while disabled so re-enable starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      pwm_cnt  <= '0;
    end else if (!bus.enable) begin
      tick_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
    end
  end

  // Brightness levels and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        lvl[i] <= '0;
      end
      leds_q   <= '0;
      active_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        lvl[i] <= lvl_nxt[i];
      end
      leds_q   <= leds_nxt;
      active_q <= any_lit;
    end
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader with TICK_DIV=10, MAX=15, FADE_STEP=4.
// Reference model tracks brightness per LED and derives PWM phase and tick
// from the count of enabled cycles, checking both outputs every clock.
module tb_led_trail_fader;

  localparam int TICK_DIV = 10;
  localparam int MAXV     = 15;
  localparam int STEP     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state
  int         m_lvl [8];
  logic [7:0] m_pq;
  logic [7:0] m_leds;
  logic       m_act;
  int         m_n;     // enabled cycles since reset / last disable

  led_trail_fader_if bus ();

  led_trail_fader #(
    .CLK_FREQ (1000),
    .FADE_HZ  (100),
    .PWM_BITS (4),
    .FADE_STEP(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    m_pq = 8'h00; m_leds = 8'h00; m_act = 1'b0; m_n = 0;
  endtask

  // Advance one clock, update the model with the inputs seen at the edge, settle.
  task automatic tick_clk();
    int old_lvl [8];
    bit tk;
    int ph;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      old_lvl = m_lvl;
      m_act = 1'b0;
      for (int i = 0; i < 8; i++) if (old_lvl[i] != 0) m_act = 1'b1;
      if (!bus.enable) begin
        for (int i = 0; i < 8; i++) m_lvl[i] = 0;
        m_leds = 8'h00;
        m_n = 0;
      end else begin
        tk = ((m_n % TICK_DIV) == TICK_DIV - 1);
        ph = m_n % MAXV;
        for (int i = 0; i < 8; i++) begin
          m_leds[i] = (ph < old_lvl[i]);
          if (m_pq[i]) m_lvl[i] = MAXV;
          else if (tk) m_lvl[i] = (old_lvl[i] < STEP) ? 0 : old_lvl[i] - STEP;
        end
        m_n++;
      end
      m_pq = bus.pattern_in;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0; bus.pattern_in = 8'hFF; bus.enable = 1'b1;
    model_reset();
    #1;
    total++;
    if (bus.leds_out !== 8'h00 || bus.active !== 1'b0) begin
      bad++; $display("FAIL reset_async leds=%h exp=00 active=%b exp=0", bus.leds_out, bus.active);
    end
    repeat (4) begin
      tick_clk();
      total++;
      if (bus.leds_out !== 8'h00 || bus.active !== 1'b0) begin
        bad++; $display("FAIL reset_hold leds=%h exp=00 active=%b exp=0", bus.leds_out, bus.active);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick_clk();
      exp = (k >= 3) ? 8'hFF : 8'h00;
      total++;
      if (bus.leds_out !== exp) begin
        bad++; $display("FAIL reset_release_latency clk=%0d leds=%h exp=%h", k, bus.leds_out, exp);
      end
      total++;
      if (bus.active !== m_act) begin
        bad++; $display("FAIL reset_release_active clk=%0d active=%b exp=%b", k, bus.active, m_act);
      end
    end
  endtask

  task automatic test_single();
    bus.pattern_in = 8'h01;
    for (int k = 1; k <= 60; k++) begin
      tick_clk();
      total++;
      if (bus.leds_out !== m_leds || bus.active !== m_act) begin
        bad++; $display("FAIL single_model clk=%0d leds=%h exp=%h active=%b exp=%b", k, bus.leds_out, m_leds, bus.active, m_act);
      end
      if (k >= 50) begin
        total++;
        if (bus.leds_out !== 8'h01 || bus.active !== 1'b1) begin
          bad++; $display("FAIL single_steady leds=%h exp=01 active=%b exp=1", bus.leds_out, bus.active);
        end
      end
    end
  endtask

  task automatic test_decay();
    int on_cnt = 0;
    bus.pattern_in = 8'h00;
    for (int k = 1; k <= 70; k++) begin
      tick_clk();
      on_cnt += int'(bus.leds_out[0]);
      total++;
      if (bus.leds_out !== m_leds || bus.active !== m_act) begin
        bad++; $display("FAIL decay_model clk=%0d leds=%h exp=%h active=%b exp=%b", k, bus.leds_out, m_leds, bus.active, m_act);
      end
    end
    total++;
    if (bus.leds_out !== 8'h00 || bus.active !== 1'b0) begin
      bad++; $display("FAIL decay_final leds=%h exp=00 active=%b exp=0", bus.leds_out, bus.active);
    end
    // Fade must take time: LED 0 lit for part of the tail, not for all of it.
    total++;
    if (on_cnt < 10 || on_cnt > 40) begin
      bad++; $display("FAIL decay_tail on_cycles=%0d expected_range=10..40", on_cnt);
    end
  endtask

  task automatic test_attack_on_tick();
    int guard = 0;
    int on_cnt = 0;
    bus.pattern_in = 8'h01;
    repeat (3) tick_clk();
    bus.pattern_in = 8'h00;
    while (!(m_lvl[0] == 3 && (m_n % TICK_DIV) == TICK_DIV - 2) && guard < 200) begin
      tick_clk(); guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++; $display("FAIL attack_setup timeout lvl=%0d exp=3", m_lvl[0]);
    end
    bus.pattern_in = 8'h01;   // captured into pattern_q on the edge before the tick
    tick_clk();
    bus.pattern_in = 8'h00;
    tick_clk();               // tick edge: attack must win over decay
    for (int k = 1; k <= 10; k++) begin
      tick_clk();
      on_cnt += int'(bus.leds_out[0]);
      total++;
      if (bus.leds_out !== m_leds || bus.active !== m_act) begin
        bad++; $display("FAIL attack_model clk=%0d leds=%h exp=%h active=%b exp=%b", k, bus.leds_out, m_leds, bus.active, m_act);
      end
    end
    total++;
    if (on_cnt !== 10) begin
      bad++; $display("FAIL attack_wins on_cycles=%0d exp=10", on_cnt);
    end
  endtask

  task automatic test_disable();
    int guard = 0;
    bus.pattern_in = 8'h01;
    repeat (3) tick_clk();
    bus.pattern_in = 8'h00;
    while (m_lvl[0] != 7 && guard < 200) begin
      tick_clk(); guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++; $display("FAIL disable_setup timeout lvl=%0d exp=7", m_lvl[0]);
    end
    bus.enable = 1'b0;
    tick_clk();
    total++;
    if (bus.leds_out !== 8'h00 || bus.active !== 1'b1) begin
      bad++; $display("FAIL disable_first_edge leds=%h exp=00 active=%b exp=1", bus.leds_out, bus.active);
    end
    tick_clk();
    total++;
    if (bus.active !== 1'b0) begin
      bad++; $display("FAIL disable_active active=%b exp=0", bus.active);
    end
    bus.enable = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick_clk();
      total++;
      if (bus.leds_out !== 8'h00 || bus.active !== 1'b0) begin
        bad++; $display("FAIL reenable_dark clk=%0d leds=%h exp=00 active=%b exp=0", k, bus.leds_out, bus.active);
      end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] pat = 8'h1F;
    logic [7:0] prev = 8'h00;
    logic [7:0] newb;
    for (int s = 0; s < 8; s++) begin
      bus.pattern_in = pat;
      newb = pat & ~prev;
      for (int k = 1; k <= 20; k++) begin
        tick_clk();
        total++;
        if (bus.leds_out !== m_leds || bus.active !== m_act) begin
          bad++; $display("FAIL rotate_model shift=%0d clk=%0d leds=%h exp=%h active=%b exp=%b", s, k, bus.leds_out, m_leds, bus.active, m_act);
        end
        if (k == 3) begin
          total++;
          if ((bus.leds_out & newb) !== newb) begin
            bad++; $display("FAIL rotate_attack shift=%0d leds=%h new_bits=%h", s, bus.leds_out, newb);
          end
        end
      end
      prev = pat;
      pat = {pat[6:0], pat[7]};
    end
  endtask

  task automatic test_random();
    for (int k = 1; k <= 400; k++) begin
      if ($urandom_range(0, 7) == 0) bus.pattern_in = 8'($urandom);
      bus.enable = ($urandom_range(0, 24) != 0);
      tick_clk();
      total++;
      if (bus.leds_out !== m_leds || bus.active !== m_act) begin
        bad++; $display("FAIL random_model clk=%0d leds=%h exp=%h active=%b exp=%b", k, bus.leds_out, m_leds, bus.active, m_act);
      end
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_mid_fade();
    int guard = 0;
    bus.pattern_in = 8'h01;
    repeat (3) tick_clk();
    bus.pattern_in = 8'h00;
    while (m_lvl[0] != 11 && guard < 200) begin
      tick_clk(); guard++;
    end
    tick_clk();
    total++;
    if (guard >= 200 || bus.active !== 1'b1) begin
      bad++; $display("FAIL midfade_setup guard=%0d active=%b exp=1", guard, bus.active);
    end
    @(negedge clk); rst_n = 1'b0; model_reset();
    #1;
    total++;
    if (bus.leds_out !== 8'h00 || bus.active !== 1'b0) begin
      bad++; $display("FAIL midfade_reset_async leds=%h exp=00 active=%b exp=0", bus.leds_out, bus.active);
    end
    repeat (2) tick_clk();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      total++;
      if (bus.leds_out !== 8'h00 || bus.active !== 1'b0) begin
        bad++; $display("FAIL midfade_after_reset clk=%0d leds=%h exp=00 active=%b exp=0", k, bus.leds_out, bus.active);
      end
    end
  endtask

  initial begin
    bus.pattern_in = 8'h00;
    bus.enable = 1'b1;
    test_reset();
    test_single();
    test_decay();
    test_attack_on_tick();
    test_disable();
    test_rotate();
    test_random();
    test_reset_mid_fade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
